// File: rtl/multiword_adder.sv
// Pipelined multi-word adder: carries chain across beats, one registered output stage.
// Optional subtract mode is compiled in with `define SUBTRACT_EN.
module multiword_adder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_last,
    output logic             out_ovf,
    output logic [IDX_W-1:0] out_idx
);

    typedef enum logic {
        IDLE,
        CHAIN
    } state_e;

    state_e             state_q, state_d;
    logic               carry_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_sum_q;
    logic               out_carry_q;
    logic               out_last_q;
    logic               out_ovf_q;
    logic [IDX_W-1:0]   out_idx_q;

    logic               accept;
    logic               first;
    logic               sub_cur;
    logic               cin;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     full_sum;
    logic               ovf_d;

    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign first    = (state_q == IDLE);

`ifdef SUBTRACT_EN
    logic sub_q;

    // Mode is taken from in_sub on the first beat and held for the rest of the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q <= 1'b0;
        end else if (accept && first) begin
            sub_q <= in_sub;
        end
    end

    assign sub_cur = first ? in_sub : sub_q;
`else
    logic unused_sub;

    assign unused_sub = in_sub;
    assign sub_cur    = 1'b0;
`endif

    assign b_eff    = sub_cur ? ~in_b : in_b;
    assign cin      = first ? sub_cur : carry_q;
    assign full_sum = {1'b0, in_a} + {1'b0, b_eff} + (WIDTH + 1)'(cin);
    assign ovf_d    = in_last && (in_a[WIDTH-1] == b_eff[WIDTH-1])
                              && (full_sum[WIDTH-1] != in_a[WIDTH-1]);

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = in_last ? IDLE : CHAIN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_sum_q   <= full_sum[WIDTH-1:0];
                out_carry_q <= full_sum[WIDTH];
                carry_q     <= full_sum[WIDTH];
                out_last_q  <= in_last;
                out_ovf_q   <= ovf_d;
                // Index wraps silently; the carry chain does not depend on it.
                out_idx_q   <= first ? '0 : out_idx_q + IDX_W'(1);
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_carry = out_carry_q;
    assign out_last  = out_last_q;
    assign out_ovf   = out_ovf_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_multiword_adder.sv
// Self-checking bench for multiword_adder: directed cases plus random transactions
// checked against a whole-operand arithmetic model.
module tb_multiword_adder;

    localparam int W     = 8;
    localparam int IDX_W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_last;
    logic           in_sub;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_sum;
    logic           out_carry;
    logic           out_last;
    logic           out_ovf;
    logic [IDX_W-1:0] out_idx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } exp_t;

    multiword_adder #(.WIDTH(W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_last  (out_last),
        .out_ovf   (out_ovf),
        .out_idx   (out_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-operand model: beat k of an n-word transaction sees the low (k+1) words
    // of A and B added (or subtracted) as plain integers.
    function automatic exp_t model(input int n, input int k, input longint unsigned a,
                                   input longint unsigned b, input logic sub);
        exp_t            e;
        int              nb   = W * (k + 1);
        int              nbt  = W * n;
        longint unsigned lim  = 64'd1 << nb;
        longint unsigned al   = a & (lim - 1);
        longint unsigned bl   = b & (lim - 1);
        longint unsigned r;
        longint          sa, sb, sr, hi, lo;
        logic            sub_eff;
`ifdef SUBTRACT_EN
        sub_eff = sub;
`else
        sub_eff = 1'b0;
`endif
        r       = sub_eff ? (al + lim - bl) : (al + bl);
        e.sum   = W'((r >> (W * k)) & 64'hFF);
        e.carry = 1'(r >> nb);
        sa = (((a >> (nbt - 1)) & 1) != 0) ? longint'(a) - longint'(64'd1 << nbt) : longint'(a);
        sb = (((b >> (nbt - 1)) & 1) != 0) ? longint'(b) - longint'(64'd1 << nbt) : longint'(b);
        sr = sub_eff ? sa - sb : sa + sb;
        hi = longint'(64'd1 << (nbt - 1)) - 1;
        lo = -longint'(64'd1 << (nbt - 1));
        e.ovf = (k == n - 1) && (sr > hi || sr < lo);
        return e;
    endfunction

    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic last, input logic sub);
        int budget = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_sub   = sub;
        while (in_ready !== 1'b1 && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (budget >= 50) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_beat(input string tag, input exp_t e, input logic last, input int idx);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"},   32'(out_sum),   32'(e.sum));
        check({tag, "_carry"}, 32'(out_carry), 32'(e.carry));
        check({tag, "_last"},  32'(out_last),  32'(last));
        check({tag, "_ovf"},   32'(out_ovf),   32'(e.ovf));
        check({tag, "_idx"},   32'(out_idx),   32'(idx % (1 << IDX_W)));
    endtask

    // Later beats drive a random in_sub to show the mode is latched on the first beat.
    task automatic run_txn(input string tag, input int n, input logic [31:0] a_full,
                           input logic [31:0] b_full, input logic sub);
        for (int k = 0; k < n; k++) begin
            logic s = (k == 0) ? sub : 1'($urandom);
            send_beat(a_full[W*k +: W], b_full[W*k +: W], k == n - 1, s);
            check_beat(tag, model(n, k, 64'(a_full), 64'(b_full), sub), k == n - 1, k);
        end
    endtask

    initial begin
        exp_t e;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready),  32'd0);
        @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum",   32'(out_sum),   32'd0);
        check("rst_carry", 32'(out_carry), 32'd0);
        check("rst_last",  32'(out_last),  32'd0);
        check("rst_ovf",   32'(out_ovf),   32'd0);
        check("rst_idx",   32'(out_idx),   32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed cases
        run_txn("single_ff_01", 1, 32'hFF,   32'h01,   1'b0);
        run_txn("chain_01ff",   2, 32'h01FF, 32'h0001, 1'b0);
        run_txn("ovf_7f_01",    1, 32'h7F,   32'h01,   1'b0);
        run_txn("sub_05_07",    1, 32'h05,   32'h07,   1'b1);
        run_txn("sub_chain",    3, 32'h000100, 32'h000001, 1'b1);

        // Drain: no new beat, out_valid drops
        @(posedge clk);
        #1;
        check("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        send_beat(8'h3C, 8'h41, 1'b1, 1'b0);
        e = model(1, 0, 64'h3C, 64'h41, 1'b0);
        check_beat("bp_first", e, 1'b1, 0);
        in_valid = 1'b1;
        in_a     = 8'h90;
        in_b     = 8'h90;
        in_last  = 1'b1;
        in_sub   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check_beat("bp_hold", e, 1'b1, 0);
        end
        out_ready = 1'b1;
        send_beat(8'h90, 8'h90, 1'b1, 1'b0);
        check_beat("bp_replace", model(1, 0, 64'h90, 64'h90, 1'b0), 1'b1, 0);

        // Reset mid-chain: stale carry must not leak into the next transaction
        send_beat(8'hFF, 8'h01, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        run_txn("after_rst", 1, 32'h00, 32'h00, 1'b0);

        // Long chain across the index wrap: carry ripples through every beat
        for (int k = 0; k < 18; k++) begin
            send_beat(8'hFF, (k == 0) ? 8'h01 : 8'h00, k == 17, 1'b0);
            e.sum   = 8'h00;
            e.carry = 1'b1;
            e.ovf   = 1'b0;
            check_beat("wrap", e, k == 17, k);
        end

        // Random transactions
        for (int t = 0; t < 40; t++) begin
            int          n    = int'($urandom_range(1, 4));
            logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (W * n)) - 1);
            run_txn("rand", n, $urandom & mask, $urandom & mask, 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiword_adder.md
# multiword_adder

Parametrised, pipelined multi-word adder that extends our single-bit half-adder datapath to WIDTH-bit operands. Carry chains across consecutive beats, so arbitrarily long operands can be added one word per cycle. It sits between an operand source and a result sink, with a valid/ready handshake on both sides. One registered output stage: the result appears one cycle after acceptance.

## Interface
Parameters:
- WIDTH, 8, operand/result word width in bits (≥2)
- IDX_W, 4, width of the beat-index counter

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block can accept a beat this cycle
- in_a  input  WIDTH  operand A word, least-significant word first
- in_b  input  WIDTH  operand B word
- in_last  input  1  this is the final (most-significant) word of the operand
- in_sub  input  1  subtract mode; sampled on the first beat only, ignored without SUBTRACT_EN
- out_valid  output  1  result beat present
- out_ready  input  1  sink accepts the result beat
- out_sum  output  WIDTH  result word
- out_carry  output  1  carry-out of this word (in subtract mode, 1 = no borrow)
- out_last  output  1  copy of in_last for this beat
- out_ovf  output  1  signed overflow; meaningful only when out_last=1, else 0
- out_idx  output  IDX_W  beat index within the transaction

## Operation
- Accept: beat is taken when in_valid && in_ready.
- in_ready = !rst && (!out_valid || out_ready).
- FSM states:
  - IDLE: next accepted beat is a first beat.
  - CHAIN: a transaction is in progress.
- FSM transitions:
  - IDLE→CHAIN on an accepted beat with in_last=0.
  - CHAIN→IDLE on an accepted beat with in_last=1.
  - A first beat with in_last=1 stays in IDLE.
- On a first beat, the block latches mode: sub_q = in_sub (forced 0 without SUBTRACT_EN).
- Effective B per beat: b_eff = sub ? ~in_b : in_b, where sub is in_sub on the first beat and sub_q on later beats.
- Carry-in per beat: cin = sub on a first beat, carry_q otherwise.
- Arithmetic is (WIDTH+1)-bit: {c, s} = in_a + b_eff + cin.
  - out_sum ← s, out_carry ← c, carry_q ← c.
- Overflow on last beats: out_ovf ← (in_a[MSB] == b_eff[MSB]) && (s[MSB] != in_a[MSB]). On all other beats out_ovf ← 0.
- out_idx is 0 on a first beat and increments on each further beat. It wraps modulo 2^IDX_W silently; the carry chain is unaffected by the wrap.
- Output register:
  - Loaded on accept; out_valid ← 1.
  - out_valid cleared when out_valid && out_ready && no new accept.
  - Simultaneous drain and accept: the new beat replaces the old one and out_valid stays 1.

## Timing
- Latency: exactly 1 cycle from accept edge to out_valid.
- Throughput: 1 beat per cycle while out_ready=1.
- Backpressure: when out_valid=1 and out_ready=0, in_ready=0 and all out_* hold stable.
- in_* may change freely while in_ready=0; nothing is sampled.
- Reset values, applied at the first clk edge with rst=1:
  - Outputs: out_valid=0, out_sum=0, out_carry=0, out_last=0, out_ovf=0, out_idx=0.
  - Internal state: FSM=IDLE, carry_q=0, sub_q=0.
  - in_ready=0 while rst=1.
- Reset mid-transaction:
  - Any pending output beat is dropped and the chain is abandoned.
  - The first beat after reset is a first beat: idx 0, cin = in_sub.

## Configuration
- SUBTRACT_EN:
  - Defined: in_sub selects A−B (two's complement: inverted B, carry-in 1 on the first beat), held for the whole transaction.
  - Undefined: in_sub is ignored, the block only adds, and no sub_q flop is instantiated.

## Test plan
- Single-beat add, WIDTH=8: a=0xFF, b=0x01, last=1 → next cycle out_sum=0x00, out_carry=1, out_ovf=0, out_idx=0, out_last=1.
- Two-beat chain computing 0x01FF+0x0001:
  - Beat (0xFF, 0x01, last=0) → sum 0x00, carry 1, idx 0.
  - Beat (0x01, 0x00, last=1) → sum 0x02, carry 0, idx 1, ovf 0.
- Signed overflow: 0x7F+0x01, last=1 → sum 0x80, carry 0, ovf 1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles after a result → in_ready=0 and out_* unchanged throughout.
  - Raise out_ready with a new beat present → the beat is accepted the same cycle and out_valid stays 1.
- Subtract mode: 0x05−0x07, sub=1, last=1.
  - With SUBTRACT_EN → sum 0xFE, carry 0, ovf 0.
  - Without SUBTRACT_EN → sum 0x0C, carry 0.
- Reset mid-chain:
  - Accept (0xFF, 0x01, last=0), then pulse rst for 1 cycle.
  - Then send (0x00, 0x00, last=1) → sum 0x00, carry 0, idx 0 (no stale carry).
